// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Define LOADER_CHECKSUM_EN to add the trailing checksum byte and its CHECK state.
package program_loader_pkg;

  localparam int LOADER_WORD_BYTES   = 4;
  localparam int LOADER_HEADER_BYTES = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Collects big-endian bytes into 32-bit words; word_valid fires on the byte completing a word.
module program_loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int IDX_W = $clog2(LOADER_WORD_BYTES);

  logic [IDX_W-1:0] idx_reg;
  logic [23:0]      shift_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (byte_valid) begin
      idx_reg   <= idx_reg + 1'b1;
      shift_reg <= {shift_reg[15:0], byte_data};
    end
  end

  // The completing byte is passed through so the word is usable in the same cycle.
  assign word       = {shift_reg, byte_data};
  assign word_valid = byte_valid && (idx_reg == IDX_W'(LOADER_WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a framed serial program image into processor memory while holding the core paused.
// Define LOADER_CHECKSUM_EN to require a mod-256 data checksum byte at the end of each frame.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         PAUSE_SETTLE    = 4,
  parameter int         TIMEOUT_CYCLES  = 1_000_000,
  parameter logic [2:0] WRITE_MODE_WORD = 3'd3,
  parameter logic [2:0] WRITE_MODE_NONE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxValid,
  input  logic [7:0]  rxData,
  output logic        rxReady,
  output logic        pause,
  output logic        externalMemoryControl,
  output logic [31:0] externalAddress,
  output logic [31:0] externalData,
  output logic [2:0]  externalWriteMode,
  output logic [2:0]  externalReadMode,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpuResetRequest,
  output logic [31:0] wordsWritten
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t ST_LAST = ST_CHECK;
  logic [7:0] sum_reg;
`else
  localparam loader_state_t ST_LAST = ST_DONE;
`endif

  loader_state_t state_reg, state_next;
  logic [3:0]    settle_cnt_reg;
  logic [31:0]   idle_cnt_reg, addr_reg, count_reg, data_reg, words_reg;
  logic          error_reg;
  logic          accept, field_byte, waiting, timed_out, asm_valid;
  logic [31:0]   asm_word;

  assign accept     = rxValid && rxReady;
  assign field_byte = accept && (state_reg inside {ST_ADDR, ST_COUNT, ST_DATA});
`ifdef LOADER_CHECKSUM_EN
  assign waiting    = state_reg inside {ST_ADDR, ST_COUNT, ST_DATA, ST_CHECK};
`else
  assign waiting    = state_reg inside {ST_ADDR, ST_COUNT, ST_DATA};
`endif
  assign timed_out  = waiting && !accept && (idle_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  program_loader_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_reg == ST_IDLE),
    .byte_valid(field_byte),
    .byte_data (rxData),
    .word      (asm_word),
    .word_valid(asm_valid)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:   if (accept && rxData == SYNC_BYTE) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_reg == 4'(PAUSE_SETTLE - 1)) state_next = ST_ADDR;
      ST_ADDR: begin
        if (timed_out) state_next = ST_ERROR;
        else if (asm_valid) state_next = (asm_word[1:0] != 2'b00) ? ST_ERROR : ST_COUNT;
      end
      ST_COUNT: begin
        if (timed_out) state_next = ST_ERROR;
        else if (asm_valid) state_next = (asm_word == 32'd0) ? ST_LAST : ST_DATA;
      end
      ST_DATA: begin
        if (timed_out) state_next = ST_ERROR;
        else if (asm_valid) state_next = ST_WRITE;
      end
      ST_WRITE:  state_next = (words_reg + 32'd1 == count_reg) ? ST_LAST : ST_DATA;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (timed_out) state_next = ST_ERROR;
        else if (accept) state_next = (rxData == sum_reg) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:   state_next = ST_IDLE;
      ST_ERROR:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      idle_cnt_reg   <= '0;
      addr_reg       <= '0;
      count_reg      <= '0;
      data_reg       <= '0;
      words_reg      <= '0;
      error_reg      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= (state_reg == ST_SETTLE) ? settle_cnt_reg + 4'd1 : 4'd0;
      idle_cnt_reg   <= (waiting && !accept) ? idle_cnt_reg + 32'd1 : 32'd0;
      if (state_reg == ST_IDLE && state_next == ST_SETTLE) begin
        error_reg <= 1'b0;
        words_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_reg   <= '0;
`endif
      end
      if (state_next == ST_ERROR) error_reg <= 1'b1;
      if (asm_valid) begin
        if (state_reg == ST_ADDR)  addr_reg  <= asm_word;
        if (state_reg == ST_COUNT) count_reg <= asm_word;
        if (state_reg == ST_DATA)  data_reg  <= asm_word;
      end
      // Address advances only after the store so it is stable for the whole write cycle.
      if (state_reg == ST_WRITE) begin
        addr_reg  <= addr_reg + 32'd4;
        words_reg <= words_reg + 32'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (field_byte && state_reg == ST_DATA) sum_reg <= sum_reg + rxData;
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign rxReady = state_reg inside {ST_IDLE, ST_ADDR, ST_COUNT, ST_DATA, ST_CHECK};
  assign pause   = state_reg inside {ST_SETTLE, ST_ADDR, ST_COUNT, ST_DATA, ST_WRITE, ST_CHECK};
`else
  assign rxReady = state_reg inside {ST_IDLE, ST_ADDR, ST_COUNT, ST_DATA};
  assign pause   = state_reg inside {ST_SETTLE, ST_ADDR, ST_COUNT, ST_DATA, ST_WRITE};
`endif
  assign externalMemoryControl = pause;
  assign externalAddress       = addr_reg;
  assign externalData          = data_reg;
  assign externalWriteMode     = (state_reg == ST_WRITE) ? WRITE_MODE_WORD : WRITE_MODE_NONE;
  assign externalReadMode      = 3'd0;
  assign busy                  = (state_reg != ST_IDLE);
  assign done                  = (state_reg == ST_DONE);
  assign cpuResetRequest       = (state_reg == ST_DONE);
  assign error                 = error_reg;
  assign wordsWritten          = words_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; compile with +define+LOADER_CHECKSUM_EN to cover the checksum build.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int TO     = 50;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxReady, pause, externalMemoryControl, busy, done, error, cpuResetRequest;
  logic [31:0] externalAddress, externalData, wordsWritten;
  logic [2:0]  externalWriteMode, externalReadMode;

  program_loader #(
    .SYNC_BYTE(8'hA5), .PAUSE_SETTLE(SETTLE), .TIMEOUT_CYCLES(TO),
    .WRITE_MODE_WORD(3'd3), .WRITE_MODE_NONE(3'd0)
  ) dut (
    .clk(clk), .rst(rst), .rxValid(rxValid), .rxData(rxData), .rxReady(rxReady),
    .pause(pause), .externalMemoryControl(externalMemoryControl),
    .externalAddress(externalAddress), .externalData(externalData),
    .externalWriteMode(externalWriteMode), .externalReadMode(externalReadMode),
    .busy(busy), .done(done), .error(error), .cpuResetRequest(cpuResetRequest),
    .wordsWritten(wordsWritten)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write / done monitor, sampled on the falling edge.
  int          wr_count = 0, wr_run = 0, wr_max_run = 0, wr_bad_mode = 0;
  int          done_run = 0, done_max_run = 0, crr_mismatch = 0;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  always @(negedge clk) begin
    if (externalWriteMode == 3'd3) begin
      wr_addr[4'(wr_count)] <= externalAddress;
      wr_data[4'(wr_count)] <= externalData;
      wr_count <= wr_count + 1;
      wr_run   <= wr_run + 1;
      if (wr_run + 1 > wr_max_run) wr_max_run <= wr_run + 1;
      $display("write addr=%08h data=%08h", externalAddress, externalData);
    end else begin
      wr_run <= 0;
      if (externalWriteMode != 3'd0) wr_bad_mode <= wr_bad_mode + 1;
    end
    if (done) begin
      done_run <= done_run + 1;
      if (done_run + 1 > done_max_run) done_max_run <= done_run + 1;
    end else begin
      done_run <= 0;
    end
    if (done != cpuResetRequest) crr_mismatch <= crr_mismatch + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("check %s = %08h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    while (!rxReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(rxReady), 32'd1);
    @(posedge clk);
    #1 rxValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  logic [31:0] fw [0:7];

  // Header and data after the sync byte; appends the checksum in the checksum build.
  task automatic send_body(input logic [31:0] addr, input logic [31:0] cnt, input int nw);
    logic [7:0] sum = 8'h00;
    send_word(addr);
    send_word(cnt);
    for (int i = 0; i < nw; i++) begin
      send_word(fw[i]);
      sum = sum + fw[i][31:24] + fw[i][23:16] + fw[i][15:8] + fw[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum);
`else
    if (sum == 8'h00) rxData = 8'h00;
`endif
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_crr"}, 32'(cpuResetRequest), 32'd1);
    check({tag, "_pause_drop"}, 32'(pause), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rxready", 32'(rxReady), 32'd1);
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_emc", 32'(externalMemoryControl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_crr", 32'(cpuResetRequest), 32'd0);
    check("rst_wmode", 32'(externalWriteMode), 32'd0);
    check("rst_rmode", 32'(externalReadMode), 32'd0);
    check("rst_words", wordsWritten, 32'd0);
    check("rst_addr", externalAddress, 32'd0);
    check("rst_data", externalData, 32'd0);
    rst = 1'b0;

    // Two-word frame at 0x100, with settle-window timing
    base = wr_count;
    send_byte(8'hA5);
    @(negedge clk);
    check("t1_pause", 32'(pause), 32'd1);
    check("t1_emc", 32'(externalMemoryControl), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    n = 0;
    while (!rxReady && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t1_settle_cycles", 32'(n), 32'(SETTLE));
    fw[0] = 32'h11223344;
    fw[1] = 32'hAABBCCDD;
    send_body(32'h00000100, 32'd2, 2);
    wait_done("t1");
    check("t1_nwrites", 32'(wr_count - base), 32'd2);
    check("t1_addr0", wr_addr[4'(base)], 32'h00000100);
    check("t1_data0", wr_data[4'(base)], 32'h11223344);
    check("t1_addr1", wr_addr[4'(base + 1)], 32'h00000104);
    check("t1_data1", wr_data[4'(base + 1)], 32'hAABBCCDD);
    check("t1_words", wordsWritten, 32'd2);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Noise, then an empty frame
    base = wr_count;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    check("t2_noise_busy", 32'(busy), 32'd0);
    check("t2_noise_pause", 32'(pause), 32'd0);
    send_byte(8'hA5);
    send_word(32'h00000000);
    send_word(32'h00000000);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk);
    check("t2_done_next", 32'(done), 32'd1);
    @(negedge clk);
    check("t2_nwrites", 32'(wr_count - base), 32'd0);
    check("t2_words", wordsWritten, 32'd0);

    // Misaligned address, then a clean frame clears the error
    base = wr_count;
    send_byte(8'hA5);
    send_word(32'h00000102);
    @(negedge clk);
    check("t3_error", 32'(error), 32'd1);
    check("t3_pause", 32'(pause), 32'd0);
    @(negedge clk);
    check("t3_error_sticky", 32'(error), 32'd1);
    check("t3_busy_idle", 32'(busy), 32'd0);
    send_byte(8'hA5);
    @(negedge clk);
    check("t3_error_clear", 32'(error), 32'd0);
    fw[0] = 32'hDEADBEEF;
    send_body(32'h00000200, 32'd1, 1);
    wait_done("t3");
    check("t3_nwrites", 32'(wr_count - base), 32'd1);
    check("t3_addr", wr_addr[4'(base)], 32'h00000200);
    check("t3_data", wr_data[4'(base)], 32'hDEADBEEF);

    // Stream stops after two data bytes
    base = wr_count;
    send_byte(8'hA5);
    send_word(32'h00000300);
    send_word(32'h00000001);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (TO) @(negedge clk);
    check("t4_no_error_early", 32'(error), 32'd0);
    check("t4_still_busy", 32'(pause), 32'd1);
    @(negedge clk);
    check("t4_error_at_timeout", 32'(error), 32'd1);
    check("t4_pause_drop", 32'(pause), 32'd0);
    @(negedge clk);
    check("t4_nwrites", 32'(wr_count - base), 32'd0);

    // Address wraps past 0xFFFFFFFC; sync value inside data is ordinary data
    base = wr_count;
    fw[0] = 32'hA5000001;
    fw[1] = 32'h12345678;
    send_byte(8'hA5);
    send_body(32'hFFFFFFFC, 32'd2, 2);
    wait_done("t5");
    check("t5_nwrites", 32'(wr_count - base), 32'd2);
    check("t5_addr0", wr_addr[4'(base)], 32'hFFFFFFFC);
    check("t5_data0", wr_data[4'(base)], 32'hA5000001);
    check("t5_addr1", wr_addr[4'(base + 1)], 32'h00000000);
    check("t5_data1", wr_data[4'(base + 1)], 32'h12345678);

    // Reset in the middle of DATA
    base = wr_count;
    send_byte(8'hA5);
    send_word(32'h00000400);
    send_word(32'h00000001);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rxready", 32'(rxReady), 32'd1);
    check("t6_pause", 32'(pause), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_words", wordsWritten, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_nwrites", 32'(wr_count - base), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    base = wr_count;
    send_byte(8'hA5);
    send_word(32'h00000500);
    send_word(32'h00000001);
    send_word(32'h01020304);
    send_byte(8'h0A);
    wait_done("t7");
    send_byte(8'hA5);
    send_word(32'h00000504);
    send_word(32'h00000001);
    send_word(32'h01020304);
    send_byte(8'h0B);
    @(negedge clk);
    check("t7_bad_sum_error", 32'(error), 32'd1);
    check("t7_bad_sum_done", 32'(done), 32'd0);
    @(negedge clk);
    check("t7_nwrites", 32'(wr_count - base), 32'd2);
`endif

    @(negedge clk);
    check("mon_write_width", 32'(wr_max_run), 32'd1);
    check("mon_bad_wmode", 32'(wr_bad_mode), 32'd0);
    check("mon_done_width", 32'(done_max_run), 32'd1);
    check("mon_crr_match", 32'(crr_mismatch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
